cam_frame_sram_writer: RTL and testbench
========================================

# cam_frame_sram_writer

Parametrised camera-to-SRAM frame writer: captures one pixel stream frame per trigger into a selectable SRAM bank, with ping-pong banking in continuous mode. Sits between the camera capture block and the SRAM arbiter. A small skid FIFO decouples camera strobes from SRAM grant stalls. It reports frame completion, the completed bank and overflow.

## Interface
- DATA_W, 16, pixel/SRAM data width
- CAM_ADDR_W, 17, camera pixel index width
- SRAM_ADDR_W, 19, SRAM address width
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- BANK_STRIDE, 131072, address offset between banks; must be ≥ H_RES*V_RES
- FIFO_DEPTH, 4, skid FIFO entries; power of two, ≥ 2

Ports:
- wclk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  start/keep capturing
- continuous  in  1  0 = single frame; 1 = ping-pong frames while enable is high
- cam_addr  in  CAM_ADDR_W  pixel index
- cam_data  in  DATA_W  pixel value
- cam_we  in  1  pixel valid strobe
- sram_grant  in  1  arbiter grants the SRAM port this cycle
- sram_req  out  1  FIFO non-empty, requesting the port
- sram_ce, sram_we, sram_oe  out  1  SRAM strobes; sram_oe is always 0
- sram_addr  out  SRAM_ADDR_W  bank*BANK_STRIDE + pixel index
- sram_data  out  DATA_W  write data
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse when a frame is fully written
- frame_bank  out  1  bank of the last completed frame
- overflow  out  1  sticky; cleared on leaving IDLE

## Operation
- Reset value of every output is 0. Internal state: bank=0, FIFO empty, state IDLE.
- LAST = H_RES*V_RES-1 (76799 by default).
- States:
  - IDLE: when enable=1 → SYNC, clearing overflow.
  - SYNC: wait for cam_we=1 with cam_addr=0. That pixel is pushed to the FIFO → CAPTURE.
  - CAPTURE: every cam_we with cam_addr≤LAST pushes {cam_addr, cam_data}. Indices >LAST are dropped silently. Pushing LAST sets last_seen → DRAIN.
  - DRAIN: no pushes. Wait until the FIFO is empty and no write is in flight → DONE.
  - DONE: done=1 for one cycle. frame_bank←bank.
    - continuous=1 and enable=1: bank toggles → SYNC.
    - otherwise: bank unchanged → IDLE.
- Write port is independent of the capture state machine. Each entry is written in two cycles:
  - W1: pop, drive sram_addr/sram_data, sram_ce=sram_we=1.
  - W2: hold all signals.
  - Next cycle: strobes return to 0 unless a new W1 starts.
- W1 starts only when the FIFO is non-empty and sram_grant=1. A grant drop during W2 does not abort the write.
- FIFO full while cam_we pushes: pixel is dropped, overflow←1, frame still completes. A push and a pop in the same cycle on a full FIFO is accepted.
- enable falling mid-frame: the current frame completes and is reported, then the block goes to IDLE.
- rst_n low at any time: immediate return to reset values. An in-flight SRAM write is abandoned.

## Timing
- Accept edge N (cam_we high, FIFO empty, grant high):
  - W1 strobes visible in cycle N+1, W2 in N+2.
  - Back-to-back write throughput is 1 pixel per 2 cycles.
- done asserts the cycle after W2 of the last FIFO entry.
- sram_req is combinational from FIFO non-empty. All other outputs are registered.
- Sustained camera rate above 1 pixel per 2 cycles, or grant starvation longer than FIFO_DEPTH pixels, causes overflow.

## Structure
- Package cam_sram_pkg holds:
  - state enum (IDLE, SYNC, CAPTURE, DRAIN, DONE)
  - FRAME_PIX/LAST derivation function
  - pixel entry struct {addr, data}
- Sub-module: pix_skid_fifo, a synchronous FIFO parametrised by width and depth, with full/empty flags and simultaneous push/pop.

## Test plan
- Single frame, 4×2 resolution, grant=1, a pixel every 3 cycles, indices 0..7 → eight 2-cycle writes at addresses 0..7 with the matching data; one done pulse; frame_bank=0; back to IDLE.
- Continuous, 4×2, two frames → first frame writes to 0..7, second to BANK_STRIDE+0..7; done pulses twice; frame_bank goes 0 then 1.
- SYNC entered with the camera mid-frame at index 5 → no writes until index 0 arrives; index 0 itself is written.
- grant held low for 6 pixels with FIFO_DEPTH=4 → 4 stored, 2 dropped, overflow=1; the frame still completes with done.
- rst_n pulsed low during a W2 → all outputs 0 in the same cycle; after release, enable restarts cleanly at bank 0.

Source files
------------

// File: rtl/cam_sram_pkg.sv
// Shared types for the camera frame writer: capture states, write phases, pixel entry.
// Frame geometry helpers derive the pixel count and the last valid pixel index.
package cam_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CAPTURE,
    DRAIN,
    DONE
  } cap_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_W1,
    WR_W2
  } wr_phase_t;

  localparam int unsigned PIX_ADDR_W = 17;
  localparam int unsigned PIX_DATA_W = 16;

  // Default-geometry entry; the writer builds a width-matched copy from its parameters.
  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [PIX_DATA_W-1:0] data;
  } pix_entry_t;

  function automatic int unsigned frame_pix(input int unsigned h_res, input int unsigned v_res);
    return h_res * v_res;
  endfunction

  function automatic int unsigned frame_last(input int unsigned h_res, input int unsigned v_res);
    return frame_pix(h_res, v_res) - 1;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Synchronous FIFO: one-cycle push-to-pop visibility, combinational read data at head.
// Push is refused when full unless a pop happens in the same cycle.
module pix_skid_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cam_frame_sram_writer.sv
// Captures one camera frame per trigger into an SRAM bank (ping-pong in continuous mode).
// Pixel-to-W1 latency 1 cycle, 2 cycles per write; grant stalls absorbed by the skid FIFO, overflow drops pixels.
module cam_frame_sram_writer
  import cam_sram_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CAM_ADDR_W  = 17,
  parameter int unsigned SRAM_ADDR_W = 19,
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned BANK_STRIDE = 131072,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   wclk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   continuous,
  input  logic [CAM_ADDR_W-1:0]  cam_addr,
  input  logic [DATA_W-1:0]      cam_data,
  input  logic                   cam_we,
  input  logic                   sram_grant,
  output logic                   sram_req,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic                   sram_oe,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_data,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_bank,
  output logic                   overflow
);

  localparam logic [CAM_ADDR_W-1:0] LAST = CAM_ADDR_W'(frame_last(H_RES, V_RES));

  typedef struct packed {
    logic [CAM_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } pix_t;

  cap_state_t             state;
  wr_phase_t              wr_phase;
  logic                   bank;
  pix_t                   push_ent;
  pix_t                   pop_ent;
  logic                   push_req;
  logic                   push_drop;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [SRAM_ADDR_W-1:0] bank_base;

  assign push_ent  = '{addr: cam_addr, data: cam_data};
  assign sram_req  = !fifo_empty;
  assign sram_oe   = 1'b0;
  assign bank_base = bank ? SRAM_ADDR_W'(BANK_STRIDE) : '0;

  // A new write may begin in the W2 cycle of the previous one, giving 2 cycles per pixel.
  assign pop       = !fifo_empty && sram_grant && (wr_phase != WR_W1);
  assign push_drop = push_req && fifo_full && !pop;

  always_comb begin
    push_req = 1'b0;
    case (state)
      SYNC:    push_req = cam_we && (cam_addr == '0);
      CAPTURE: push_req = cam_we && (cam_addr <= LAST);
      default: push_req = 1'b0;
    endcase
  end

  pix_skid_fifo #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (pop_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_bank <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push_drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= SYNC;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        SYNC: begin
          if (push_req) state <= (LAST == '0) ? DRAIN : CAPTURE;
        end
        CAPTURE: begin
          // The last index ends the frame even if it was dropped on a full FIFO.
          if (cam_we && (cam_addr == LAST)) state <= DRAIN;
        end
        DRAIN: begin
          // A write in W2 completes on this edge, so it no longer counts as in flight.
          if (fifo_empty && (wr_phase != WR_W1)) begin
            state      <= DONE;
            done       <= 1'b1;
            frame_bank <= bank;
          end
        end
        DONE: begin
          if (continuous && enable) begin
            bank  <= ~bank;
            state <= SYNC;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_phase  <= WR_IDLE;
      sram_ce   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
    end else if (pop) begin
      wr_phase  <= WR_W1;
      sram_ce   <= 1'b1;
      sram_we   <= 1'b1;
      sram_addr <= bank_base + SRAM_ADDR_W'(pop_ent.addr);
      sram_data <= pop_ent.data;
    end else if (wr_phase == WR_W1) begin
      wr_phase <= WR_W2;
    end else begin
      wr_phase <= WR_IDLE;
      sram_ce  <= 1'b0;
      sram_we  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_frame_sram_writer.sv
// Randomized scoreboard bench for cam_frame_sram_writer on a 4x2 frame with a 4-entry FIFO.
// Stimulus pushes expected writes/done events; a negedge monitor pops and compares.
module tb_cam_frame_sram_writer;

  localparam int LAST        = 7;
  localparam int BANK_STRIDE = 131072;

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
  } exp_wr_t;

  typedef struct {
    logic bank;
    logic ovf;
  } exp_done_t;

  logic        wclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        continuous;
  logic [16:0] cam_addr;
  logic [15:0] cam_data;
  logic        cam_we;
  logic        sram_grant;
  logic        sram_req;
  logic        sram_ce;
  logic        sram_we;
  logic        sram_oe;
  logic [18:0] sram_addr;
  logic [15:0] sram_data;
  logic        busy;
  logic        done;
  logic        frame_bank;
  logic        overflow;

  exp_wr_t   exp_q[$];
  exp_done_t done_q[$];
  int        n_vec = 0;
  int        n_err = 0;
  int        cyc = 0;
  int        done_seen = 0;
  int        exp_done = 0;
  int        last_w2_cyc = -100;
  logic      m_bank = 1'b0;
  bit        m_synced;
  bit        m_ended;

  cam_frame_sram_writer #(
    .DATA_W      (16),
    .CAM_ADDR_W  (17),
    .SRAM_ADDR_W (19),
    .H_RES       (4),
    .V_RES       (2),
    .BANK_STRIDE (BANK_STRIDE),
    .FIFO_DEPTH  (4)
  ) dut (
    .wclk       (wclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .continuous (continuous),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_we     (cam_we),
    .sram_grant (sram_grant),
    .sram_req   (sram_req),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .busy       (busy),
    .done       (done),
    .frame_bank (frame_bank),
    .overflow   (overflow)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(sram_req), 0);
    check({tag, "_ce"},    32'(sram_ce), 0);
    check({tag, "_we"},    32'(sram_we), 0);
    check({tag, "_oe"},    32'(sram_oe), 0);
    check({tag, "_addr"},  32'(sram_addr), 0);
    check({tag, "_data"},  32'(sram_data), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_bank"},  32'(frame_bank), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
  endtask

  // Reference: a frame starts at index 0, keeps in-range indices and ends on the last index.
  task automatic model_frame_start();
    m_synced = 0;
    m_ended  = 0;
  endtask

  task automatic expect_write(input int a, input logic [15:0] d);
    exp_q.push_back('{addr: 19'(int'(m_bank) * BANK_STRIDE + a), data: d});
  endtask

  task automatic expect_done(input logic ovf);
    done_q.push_back('{bank: m_bank, ovf: ovf});
    exp_done++;
  endtask

  task automatic model_cam(input int a, input logic [15:0] d);
    if (!m_synced) begin
      if (a == 0) begin
        m_synced = 1;
        expect_write(a, d);
      end
    end else if (!m_ended && a <= LAST) begin
      expect_write(a, d);
      if (a == LAST) begin
        m_ended = 1;
        expect_done(1'b0);
      end
    end
  endtask

  task automatic send_pixel(input int a, input logic [15:0] d, input int gap, input bit use_model);
    if (use_model) model_cam(a, d);
    cam_addr = 17'(a);
    cam_data = d;
    cam_we   = 1'b1;
    tick();
    cam_we = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_frame(input int first, input int drop_en_after, input bit with_junk);
    int junk_pos;
    junk_pos = with_junk ? int'($urandom_range(first + 1, LAST - 1)) : -1;
    for (int i = first; i <= LAST; i++) begin
      if (i == junk_pos)
        send_pixel(LAST + 1 + int'($urandom_range(0, 20)), 16'($urandom), int'($urandom_range(2, 4)), 1);
      send_pixel(i, 16'($urandom), int'($urandom_range(2, 4)), 1);
      if (i == drop_en_after) enable = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_seen < exp_done && n < 300) begin
      tick();
      n++;
    end
    check(name, done_seen, exp_done);
  endtask

  // Monitor: every two-cycle write and every done pulse is matched against the queues.
  initial begin
    bit      in_w1;
    exp_wr_t cur;
    exp_done_t dexp;
    in_w1 = 0;
    forever begin
      @(negedge wclk);
      if (!rst_n) begin
        in_w1 = 0;
      end else begin
        if (sram_ce && sram_we) begin
          if (!in_w1) begin
            in_w1 = 1;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_write: got addr %0h data %0h, required no write", sram_addr, sram_data);
              cur = '{addr: sram_addr, data: sram_data};
            end else begin
              cur = exp_q.pop_front();
              check("w1_addr", 32'(sram_addr), 32'(cur.addr));
              check("w1_data", 32'(sram_data), 32'(cur.data));
              check("w1_oe", 32'(sram_oe), 0);
            end
          end else begin
            in_w1 = 0;
            last_w2_cyc = cyc;
            check("w2_addr", 32'(sram_addr), 32'(cur.addr));
            check("w2_data", 32'(sram_data), 32'(cur.data));
          end
        end else if (in_w1) begin
          in_w1 = 0;
          n_vec++;
          n_err++;
          $display("FAIL w2_missing: got ce=%0b we=%0b, required 1 1", sram_ce, sram_we);
        end
        if (done) begin
          done_seen++;
          if (done_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1, required 0");
          end else begin
            dexp = done_q.pop_front();
            check("done_bank", 32'(frame_bank), 32'(dexp.bank));
            check("done_overflow", 32'(overflow), 32'(dexp.ovf));
            check("done_writes_left", exp_q.size(), 0);
            check("done_after_w2", cyc, last_w2_cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    int n;
    rst_n = 1'b0; enable = 1'b0; continuous = 1'b0;
    cam_addr = '0; cam_data = '0; cam_we = 1'b0; sram_grant = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single frame, pixel every 3 cycles; first pixel timed explicitly.
    continuous = 1'b0; enable = 1'b1; model_frame_start();
    tick(); tick();
    d = 16'($urandom);
    model_cam(0, d);
    cam_addr = '0; cam_data = d; cam_we = 1'b1;
    tick();
    cam_we = 1'b0;
    check("accept_req", 32'(sram_req), 1);
    check("accept_no_ce_yet", 32'(sram_ce), 0);
    check("accept_busy", 32'(busy), 1);
    tick();
    check("w1_ce_at_n1", 32'(sram_ce), 1);
    check("w1_addr_at_n1", 32'(sram_addr), 0);
    check("w1_data_at_n1", 32'(sram_data), 32'(d));
    tick();
    check("w2_ce_at_n2", 32'(sram_ce), 1);
    for (int i = 1; i <= LAST; i++) begin
      send_pixel(i, 16'($urandom), 3, 1);
      if (i == 2) enable = 1'b0;
    end
    wait_done("single_done");
    repeat (3) tick();
    check("single_idle_busy", 32'(busy), 0);

    // Continuous: bank 0 frame with a stray out-of-range index, then bank 1 frame joined mid-stream.
    continuous = 1'b1; enable = 1'b1; model_frame_start();
    tick(); tick();
    send_frame(0, -1, 1);
    wait_done("cont_done0");
    m_bank = ~m_bank;
    tick();
    model_frame_start();
    for (int i = 5; i <= LAST; i++) send_pixel(i, 16'($urandom), 2, 1);
    send_frame(0, 3, 0);
    wait_done("cont_done1");
    repeat (3) tick();
    check("cont_idle_busy", 32'(busy), 0);

    // Grant starvation: six back-to-back pixels into a 4-entry FIFO.
    continuous = 1'b0; sram_grant = 1'b0; enable = 1'b1; model_frame_start();
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      if (i < 4) expect_write(i, d);
      send_pixel(i, d, 1, 0);
    end
    check("starve_overflow", 32'(overflow), 1);
    check("starve_req", 32'(sram_req), 1);
    check("starve_no_write", 32'(sram_ce), 0);
    sram_grant = 1'b1; enable = 1'b0;
    repeat (12) tick();
    for (int i = 6; i <= LAST; i++) begin
      d = 16'($urandom);
      expect_write(i, d);
      send_pixel(i, d, 3, 0);
    end
    expect_done(1'b1);
    wait_done("starve_done");
    repeat (3) tick();
    check("starve_ovf_sticky_idle", 32'(overflow), 1);

    // Reset during W2 of a bank-1 write, then a clean restart on bank 0.
    continuous = 1'b0; enable = 1'b1; model_frame_start();
    tick(); tick();
    check("restart_clears_ovf", 32'(overflow), 0);
    send_pixel(0, 16'($urandom), 1, 1);
    n = 0;
    while (!sram_ce && n < 20) begin
      tick();
      n++;
    end
    check("pre_reset_w1", 32'(sram_ce), 1);
    tick();
    check("pre_reset_w2", 32'(sram_ce), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_w2_reset");
    exp_q.delete();
    done_q.delete();
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_bank = 1'b0;
    tick();
    enable = 1'b1; model_frame_start();
    tick(); tick();
    send_frame(0, 1, 0);
    wait_done("post_reset_done");
    repeat (4) tick();
    check("post_reset_idle_busy", 32'(busy), 0);
    check("end_writes_left", exp_q.size(), 0);
    check("end_done_left", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
